// File: rtl/vec_serial_adder.sv
// Element-serial vector add/subtract: latches one operation, pushes one element per cycle
// through an ELEN-bit ripple-carry chain, then holds the result for a valid/ready handshake.
module vec_serial_adder #(
  parameter int unsigned ELEN  = 32,
  parameter int unsigned NELEM = 4,
  parameter int unsigned ID_W  = 3,
  parameter int unsigned VL_W  = $clog2(NELEM + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [ID_W-1:0]       issue_id_i,
  input  logic                  issue_sub_i,
  input  logic [VL_W-1:0]       issue_vl_i,
  input  logic [NELEM*ELEN-1:0] issue_vs1_i,
  input  logic [NELEM*ELEN-1:0] issue_vs2_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [ID_W-1:0]       result_id_o,
  output logic [NELEM*ELEN-1:0] result_data_o,
  output logic [NELEM-1:0]      result_carry_o
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic                  sub_q, sub_d;
  logic [VL_W-1:0]       vl_q, vl_d;
  logic [VL_W-1:0]       idx_q, idx_d;
  logic [NELEM*ELEN-1:0] vs1_q, vs1_d;
  logic [NELEM*ELEN-1:0] vs2_q, vs2_d;
  logic [NELEM*ELEN-1:0] data_q, data_d;
  logic [NELEM-1:0]      carry_q, carry_d;

  logic [VL_W-1:0] vl_eff;
  logic [ELEN-1:0] op_a, op_b, chain_s;
  logic [ELEN:0]   chain_c;

  assign vl_eff = (issue_vl_i > VL_W'(NELEM)) ? VL_W'(NELEM) : issue_vl_i;

  // Element select and bit-level ripple chain; subtraction is a + ~b + 1.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < NELEM; k++) begin
      if (idx_q == VL_W'(k)) begin
        op_a = vs1_q[k*ELEN +: ELEN];
        op_b = vs2_q[k*ELEN +: ELEN];
      end
    end
    if (sub_q) op_b = ~op_b;
    chain_s    = '0;
    chain_c    = '0;
    chain_c[0] = sub_q;
    for (int i = 0; i < ELEN; i++) begin
      chain_s[i]   = op_a[i] ^ op_b[i] ^ chain_c[i];
      chain_c[i+1] = (op_a[i] & op_b[i]) | (chain_c[i] & (op_a[i] ^ op_b[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    sub_d   = sub_q;
    vl_d    = vl_q;
    idx_d   = idx_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    data_d  = data_q;
    carry_d = carry_q;
    unique case (state_q)
      StIdle: begin
        if (issue_valid_i) begin
          id_d    = issue_id_i;
          sub_d   = issue_sub_i;
          vl_d    = vl_eff;
          vs1_d   = issue_vs1_i;
          vs2_d   = issue_vs2_i;
          data_d  = '0;
          carry_d = '0;
          idx_d   = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        if (vl_q == '0) begin
          state_d = StDone;
        end else begin
          for (int k = 0; k < NELEM; k++) begin
            if (idx_q == VL_W'(k)) begin
              data_d[k*ELEN +: ELEN] = chain_s;
              carry_d[k]             = chain_c[ELEN];
            end
          end
          if (idx_q == vl_q - VL_W'(1)) state_d = StDone;
          else                          idx_d   = idx_q + VL_W'(1);
        end
      end
      StDone: begin
        if (result_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      id_q    <= '0;
      sub_q   <= 1'b0;
      vl_q    <= '0;
      idx_q   <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      data_q  <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      sub_q   <= sub_d;
      vl_q    <= vl_d;
      idx_q   <= idx_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end

  assign issue_ready_o  = (state_q == StIdle);
  assign result_valid_o = (state_q == StDone);
  assign result_id_o    = id_q;
  assign result_data_o  = data_q;
  assign result_carry_o = carry_q;

endmodule
